reset_sequencer: RTL and testbench

//  Sequences ordered release of NUM_STAGES active-low resets (e.g. PLL-fed domains, camera, display,
//  SPI) once the PLL reports stable lock. Releases each stage STAGE_DELAY cycles after the previous.
//  On lock loss or a soft-reset request, re-asserts all stage resets and re-runs the sequence.

---
 rtl/reset_seq_pkg.sv | 32 +++
 rtl/sync_2ff.sv | 33 +++
 rtl/reset_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_pkg
//   Shared types and width helpers for the reset sequencer.
//   - rseq_state_t : sequencer FSM states
//   - cnt_width()  : bits needed to hold a counter value 0..max_count
//   - idx_width()  : bits needed to index n items (never less than 1)
//   - DEF_*        : default parameter values used by the sequencer top
// ---------------------------------------------------------------------------
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,   // all stages held, filtering the lock signal
        RELEASE   = 2'd1,   // releasing stages one by one
        RUN       = 2'd2,   // all stages released
        HOLD      = 2'd3    // soft-reset hold, all stages held
    } rseq_state_t;

    localparam int DEF_NUM_STAGES  = 4;
    localparam int DEF_STAGE_DELAY = 16;
    localparam int DEF_LOCK_FILTER = 8;

    // Width of a counter that must be able to hold the value max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    // Width of an index over n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop level synchronizer for a single slow-changing asynchronous
//   signal. The output lags the input by two clk edges.
// Ports
//   clk            in  1  destination clock
//   async_reset_n  in  1  asynchronous active-low reset, clears both flops
//   d              in  1  asynchronous input level
//   q              out 1  synchronized level
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic async_reset_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//   Releases NUM_STAGES active-low resets in index order once the PLL lock
//   has been seen high for LOCK_FILTER consecutive synchronized cycles.
//   Stage k is released (k+1)*STAGE_DELAY cycles after lock filtering ends.
//   Losing lock or a soft-reset request re-asserts every stage at once and
//   re-runs the sequence (soft reset first holds for STAGE_DELAY cycles).
// Ports
//   clk             in  1           free-running sequencer clock
//   async_reset_n   in  1           asynchronous active-low reset
//   pll_locked      in  1           PLL lock, asynchronous to clk
//   soft_reset_req  in  1           single-cycle request to re-run sequence
//   stage_reset_n   out NUM_STAGES  per-stage active-low resets (registered)
//   seq_done        out 1           high while all stages are released
//   lock_lost       out 1           sticky lock-drop flag, cleared by soft reset
// ---------------------------------------------------------------------------
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int STAGE_DELAY = DEF_STAGE_DELAY,
    parameter int LOCK_FILTER = DEF_LOCK_FILTER
) (
    input  logic                  clk,
    input  logic                  async_reset_n,
    input  logic                  pll_locked,
    input  logic                  soft_reset_req,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic                  seq_done,
    output logic                  lock_lost
);

    localparam int DLY_W  = cnt_width(STAGE_DELAY);
    localparam int FILT_W = cnt_width(LOCK_FILTER);
    localparam int IDX_W  = idx_width(NUM_STAGES);

    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DELAY - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [FILT_W-1:0] FILT_FULL = FILT_W'(LOCK_FILTER);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    // -----------------------------------------------------------------------
    // Lock synchronizer
    // -----------------------------------------------------------------------
    logic lock_s;

    sync_2ff u_lock_sync (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .d             (pll_locked),
        .q             (lock_s)
    );

    // -----------------------------------------------------------------------
    // State and registers
    // -----------------------------------------------------------------------
    rseq_state_t           state_reg,     state_next;
    logic [FILT_W-1:0]     filt_cnt_reg,  filt_cnt_next;
    logic [DLY_W-1:0]      dly_cnt_reg,   dly_cnt_next;
    logic [IDX_W-1:0]      stage_idx_reg, stage_idx_next;
    logic [NUM_STAGES-1:0] stage_rst_reg, stage_rst_next;
    logic                  seq_done_reg,  seq_done_next;
    logic                  lock_lost_reg, lock_lost_next;

    // One-hot mask of the stage currently waiting for release. OR-ing this
    // into the output register is the only way a bit can rise, so bits can
    // only ever come up in index order.
    logic [NUM_STAGES-1:0] release_mask;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_release_mask
            assign release_mask[gi] = (stage_idx_reg == IDX_W'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state / next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        filt_cnt_next  = filt_cnt_reg;
        dly_cnt_next   = dly_cnt_reg;
        stage_idx_next = stage_idx_reg;
        stage_rst_next = stage_rst_reg;
        seq_done_next  = seq_done_reg;
        lock_lost_next = lock_lost_reg;

        unique case (state_reg)
            WAIT_LOCK: begin
                if (soft_reset_req) begin
                    // Restart filtering from scratch and acknowledge any
                    // previous lock loss.
                    filt_cnt_next  = '0;
                    lock_lost_next = 1'b0;
                end else if (!lock_s) begin
                    filt_cnt_next = '0;
                end else if (filt_cnt_reg == FILT_LAST) begin
                    // This edge makes LOCK_FILTER consecutive high samples.
                    filt_cnt_next  = FILT_FULL;
                    state_next     = RELEASE;
                    dly_cnt_next   = '0;
                    stage_idx_next = '0;
                end else begin
                    filt_cnt_next = filt_cnt_reg + 1'b1;
                end
            end

            RELEASE, RUN: begin
                if (soft_reset_req) begin
                    // Soft reset wins over a simultaneous lock drop, but the
                    // drop must still be recorded.
                    state_next     = HOLD;
                    dly_cnt_next   = '0;
                    stage_rst_next = '0;
                    seq_done_next  = 1'b0;
                    lock_lost_next = !lock_s;
                end else if (!lock_s) begin
                    state_next     = WAIT_LOCK;
                    filt_cnt_next  = '0;
                    stage_rst_next = '0;
                    seq_done_next  = 1'b0;
                    lock_lost_next = 1'b1;
                end else if (state_reg == RELEASE) begin
                    if (dly_cnt_reg == DLY_LAST) begin
                        dly_cnt_next   = '0;
                        stage_rst_next = stage_rst_reg | release_mask;
                        if (stage_idx_reg == IDX_LAST) begin
                            state_next    = RUN;
                            seq_done_next = 1'b1;
                        end else begin
                            stage_idx_next = stage_idx_reg + 1'b1;
                        end
                    end else begin
                        dly_cnt_next = dly_cnt_reg + 1'b1;
                    end
                end
            end

            HOLD: begin
                if (soft_reset_req) begin
                    dly_cnt_next = '0;
                end else if (dly_cnt_reg == DLY_LAST) begin
                    state_next    = WAIT_LOCK;
                    dly_cnt_next  = '0;
                    filt_cnt_next = '0;
                end else begin
                    dly_cnt_next = dly_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next     = WAIT_LOCK;
                filt_cnt_next  = '0;
                dly_cnt_next   = '0;
                stage_idx_next = '0;
                stage_rst_next = '0;
                seq_done_next  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM, counters and output registers. The reset branch is asynchronous so
    // the stage resets assert even while clk is stopped.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_reg     <= WAIT_LOCK;
            filt_cnt_reg  <= '0;
            dly_cnt_reg   <= '0;
            stage_idx_reg <= '0;
            stage_rst_reg <= '0;
            seq_done_reg  <= 1'b0;
            lock_lost_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            filt_cnt_reg  <= filt_cnt_next;
            dly_cnt_reg   <= dly_cnt_next;
            stage_idx_reg <= stage_idx_next;
            stage_rst_reg <= stage_rst_next;
            seq_done_reg  <= seq_done_next;
            lock_lost_reg <= lock_lost_next;
        end
    end

    assign stage_reset_n = stage_rst_reg;
    assign seq_done      = seq_done_reg;
    assign lock_lost     = lock_lost_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
//   Bench for reset_sequencer with NUM_STAGES=4, STAGE_DELAY=16,
//   LOCK_FILTER=8. Each scenario pushes the stage_reset_n changes it expects
//   (value and clk edge number) into a queue; a monitor pops an entry at
//   every observed change and compares. Scenario tasks also compare flags
//   and state inline.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       async_reset_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic [3:0] stage_reset_n;
    logic       seq_done;
    logic       lock_lost;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cyc;
        logic [3:0] val;
        bit         chk_cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] prev_sr = 4'b0000;

    reset_sequencer #(
        .NUM_STAGES  (4),
        .STAGE_DELAY (16),
        .LOCK_FILTER (8)
    ) dut (
        .clk            (clk),
        .async_reset_n  (async_reset_n),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .stage_reset_n  (stage_reset_n),
        .seq_done       (seq_done),
        .lock_lost      (lock_lost)
    );

    // Gated clock so the asynchronous-reset scenario can stop it low.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Edge counter: at a negedge, cyc is the number of the last posedge.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Expect the full four-stage release with stage 0 at edge 'first'.
    task automatic push_sequence(input int first);
        logic [3:0] v;
        v = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            v = {v[2:0], 1'b1};
            exp_q.push_back('{first + 16 * k, v, 1'b1});
        end
    endtask

    task automatic scoreboard_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (stage_reset_n !== prev_sr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stage_change: unexpected %b at cyc %0d, required to stay %b",
                             stage_reset_n, cyc, prev_sr);
                end else begin
                    e = exp_q.pop_front();
                    if (stage_reset_n !== e.val || seq_done !== (e.val == 4'hF) ||
                        (e.chk_cyc && cyc != e.cyc)) begin
                        errors++;
                        $display("FAIL stage_change: got %b done=%b at cyc %0d, required %b done=%b at cyc %0d",
                                 stage_reset_n, seq_done, cyc, e.val, (e.val == 4'hF), e.cyc);
                    end else begin
                        $display("stage_change: %b done=%b at cyc %0d", stage_reset_n, seq_done, cyc);
                    end
                end
                prev_sr = stage_reset_n;
            end
        end
    endtask

    task automatic test_reset();
        #2 async_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (stage_reset_n !== 4'b0000) begin
            errors++;
            $display("FAIL reset_stage: got %b required 0000", stage_reset_n);
        end
        checks++;
        if (seq_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b required 0", seq_done);
        end
        checks++;
        if (lock_lost !== 1'b0) begin
            errors++;
            $display("FAIL reset_lock_lost: got %b required 0", lock_lost);
        end
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_nominal();
        int c0;
        c0 = cyc;
        async_reset_n = 1'b1;
        pll_locked    = 1'b1;
        push_sequence(c0 + 26);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL nominal_drain: pending=%0d required 0", exp_q.size());
        end
        checks++;
        if (seq_done !== 1'b1 || lock_lost !== 1'b0) begin
            errors++;
            $display("FAIL nominal_flags: done=%b lost=%b required done=1 lost=0", seq_done, lock_lost);
        end
    endtask

    task automatic test_lock_loss();
        int c0;
        c0 = cyc;
        pll_locked = 1'b0;
        exp_q.push_back('{c0 + 3, 4'b0000, 1'b1});
        repeat (3) @(negedge clk);
        checks++;
        if (stage_reset_n !== 4'b0000 || lock_lost !== 1'b1 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL lock_loss: stage=%b lost=%b done=%b required 0000/1/0",
                     stage_reset_n, lock_lost, seq_done);
        end
        checks++;
        if (dut.state_reg !== WAIT_LOCK) begin
            errors++;
            $display("FAIL lock_loss_state: got %0d required %0d", dut.state_reg, WAIT_LOCK);
        end
        repeat (4) @(negedge clk);
    endtask

    // Relock with a one-cycle glitch after five highs; the filter restarts.
    task automatic test_filter();
        int c0;
        c0 = cyc;
        pll_locked = 1'b1;
        push_sequence(c0 + 32);
        repeat (5) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        for (int i = 0; i < 110 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL filter_drain: pending=%0d required 0", exp_q.size());
        end
        checks++;
        if (lock_lost !== 1'b1) begin
            errors++;
            $display("FAIL filter_lock_lost_sticky: got %b required 1", lock_lost);
        end
    endtask

    task automatic test_soft_reset();
        int c0;
        int c1;
        c0 = cyc;
        soft_reset_req = 1'b1;
        exp_q.push_back('{c0 + 1, 4'b0000, 1'b1});
        exp_q.push_back('{c0 + 41, 4'b0001, 1'b1});
        exp_q.push_back('{c0 + 57, 4'b0011, 1'b1});
        @(negedge clk);
        soft_reset_req = 1'b0;
        checks++;
        if (lock_lost !== 1'b0 || dut.state_reg !== HOLD) begin
            errors++;
            $display("FAIL soft_from_run: lost=%b state=%0d required lost=0 state=%0d",
                     lock_lost, dut.state_reg, HOLD);
        end
        while (cyc < c0 + 57) @(negedge clk);
        // Stage 1 has just released: request a soft reset now.
        c1 = cyc;
        soft_reset_req = 1'b1;
        exp_q.push_back('{c1 + 1, 4'b0000, 1'b1});
        push_sequence(c1 + 41);
        @(negedge clk);
        soft_reset_req = 1'b0;
        checks++;
        if (stage_reset_n !== 4'b0000 || lock_lost !== 1'b0) begin
            errors++;
            $display("FAIL soft_mid_release: stage=%b lost=%b required 0000/0", stage_reset_n, lock_lost);
        end
        for (int i = 0; i < 110 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL soft_drain: pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        int c0;
        c0 = cyc;
        soft_reset_req = 1'b1;
        exp_q.push_back('{c0 + 1, 4'b0000, 1'b1});
        exp_q.push_back('{c0 + 41, 4'b0001, 1'b1});
        @(negedge clk);
        soft_reset_req = 1'b0;
        while (cyc < c0 + 45) @(negedge clk);
        // Mid-RELEASE with stage 0 out of reset: stop the clock low.
        clk_en = 1'b0;
        exp_q.push_back('{0, 4'b0000, 1'b0});
        #2 async_reset_n = 1'b0;
        #1;
        checks++;
        if (stage_reset_n !== 4'b0000 || seq_done !== 1'b0 || lock_lost !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: stage=%b done=%b lost=%b required 0000/0/0",
                     stage_reset_n, seq_done, lock_lost);
        end
        checks++;
        if (dut.state_reg !== WAIT_LOCK) begin
            errors++;
            $display("FAIL async_reset_state: got %0d required %0d", dut.state_reg, WAIT_LOCK);
        end
        #2 async_reset_n = 1'b1;
        #1;
        push_sequence(cyc + 26);
        clk_en = 1'b1;
        for (int i = 0; i < 110 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL async_drain: pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_soft_and_lock();
        int c0;
        int c3;
        c0 = cyc;
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        // lock_s is low during this cycle; raise the soft request with it.
        soft_reset_req = 1'b1;
        exp_q.push_back('{c0 + 3, 4'b0000, 1'b1});
        @(negedge clk);
        soft_reset_req = 1'b0;
        checks++;
        if (dut.state_reg !== HOLD || lock_lost !== 1'b1 || stage_reset_n !== 4'b0000 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL soft_and_lock: state=%0d lost=%b stage=%b done=%b required %0d/1/0000/0",
                     dut.state_reg, lock_lost, stage_reset_n, seq_done, HOLD);
        end
        // Retrigger HOLD part way through; it must restart its count.
        while (cyc < c0 + 10) @(negedge clk);
        soft_reset_req = 1'b1;
        @(negedge clk);
        soft_reset_req = 1'b0;
        while (cyc < c0 + 24) @(negedge clk);
        checks++;
        if (dut.state_reg !== HOLD) begin
            errors++;
            $display("FAIL hold_restart: state=%0d at cyc %0d required %0d", dut.state_reg, cyc, HOLD);
        end
        while (cyc < c0 + 28) @(negedge clk);
        checks++;
        if (dut.state_reg !== WAIT_LOCK) begin
            errors++;
            $display("FAIL hold_exit: state=%0d at cyc %0d required %0d", dut.state_reg, cyc, WAIT_LOCK);
        end
        // Soft reset in WAIT_LOCK clears the sticky flag.
        soft_reset_req = 1'b1;
        @(negedge clk);
        soft_reset_req = 1'b0;
        checks++;
        if (lock_lost !== 1'b0 || dut.state_reg !== WAIT_LOCK) begin
            errors++;
            $display("FAIL soft_in_wait: lost=%b state=%0d required 0/%0d", lock_lost, dut.state_reg, WAIT_LOCK);
        end
        c3 = cyc;
        pll_locked = 1'b1;
        push_sequence(c3 + 26);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || seq_done !== 1'b1) begin
            errors++;
            $display("FAIL rerun_after_hold: pending=%0d done=%b required 0/1", exp_q.size(), seq_done);
        end
    endtask

    initial begin
        test_reset();
        fork
            scoreboard_monitor();
        join_none
        test_nominal();
        test_lock_loss();
        test_filter();
        test_soft_reset();
        test_async_reset();
        test_soft_and_lock();
        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
